axi_master_read_resp_buffer: RTL and testbench
==============================================

// Module: axi_master_read_resp_buffer
// PURPOSE
//  Downstream of the AXI master read-control stage. Captures each read beat that stage
//  forwards to the decoder side: data, response, ID and last flag.
//  Buffers the beats in a first-word-fall-through FIFO and drains them to the decoder
//  over a valid/ready interface. Tracks burst boundaries and reports a per-burst summary
//  (beat count, worst response). Raises almost_full so the decoder can hold off rd_trn_en.
// PARAMETERS
//  data_width  64  width of RDATA / rdata_d
//  DEPTH       16  FIFO entries; power of 2, >= 4
//  AF_MARGIN   2   almost_full asserts when count >= DEPTH-AF_MARGIN
// PORTS
//  AClk         in   1           clock; all logic is on the rising edge
//  ARst         in   1           reset; asynchronous, active-low
//  rdata_d      in   data_width  beat data from the read-control stage
//  rresp_d      in   2           beat response
//  rid_d        in   4           beat transaction ID
//  r_last_d     in   1           beat is the last of its burst; sampled with rd_rsp_en_d
//  rd_rsp_en_d  in   1           beat strobe, one cycle per beat; no back-pressure upstream
//  dout         out  data_width  head-of-FIFO data
//  dresp        out  2           head response
//  did          out  4           head ID
//  dlast        out  1           head last flag
//  dvalid       out  1           FIFO not empty
//  dready       in   1           consumer accepts the head when dvalid&dready
//  burst_done   out  1           one-cycle pulse: a last beat was written
//  burst_beats  out  9           beats in the completed burst, 1..256; held until next pulse
//  burst_resp   out  2           worst response of the completed burst; held until next pulse
//  burst_id     out  4           rid_d of the completed burst's last beat
//  almost_full  out  1           count >= DEPTH-AF_MARGIN
//  full         out  1           count == DEPTH
//  overflow     out  1           sticky: a beat was dropped
//  ovf_clr      in   1           synchronous clear of overflow
// BEHAVIOUR
//  - Reset (ARst=0, asynchronous): pointers and count are 0. All outputs are 0:
//    dout, dresp, did, dlast, dvalid, burst_done, burst_beats, burst_resp, burst_id,
//    almost_full, full, overflow. Burst FSM goes to IDLE. Reset mid-burst discards the
//    stored beats and the partial burst state with no done pulse.
//  - Push: rd_rsp_en_d=1 writes one entry at the edge. The pushed entry is visible on
//    dout/dvalid the next cycle; there is no same-cycle bypass.
//  - Pop: dvalid&dready advances the read pointer. The next entry appears the following
//    cycle, or dvalid drops if the FIFO is now empty. Head outputs are stable while
//    dvalid=1 and dready=0.
//  - Push and pop in the same cycle: count is unchanged. When full, the push is accepted
//    only if a pop happens in the same cycle.
//  - Push while full with no pop: the beat is dropped, overflow is set to 1, and the beat
//    is still counted in the burst statistics. ovf_clr=1 clears overflow; if ovf_clr and a
//    drop occur in the same cycle, the set wins.
//  - Pointers are log2(DEPTH)+1 bits and wrap naturally. full and empty are decoded from
//    the MSB and the index bits; count = wr_ptr - rd_ptr, taken modulo.
//    full and almost_full are registered from the next-state count.
//  - Burst FSM:
//    - IDLE: no beat of the current burst seen yet.
//    - BURST: one or more beats seen, last not yet seen.
//    - IDLE -> BURST on a push with last=0.
//    - IDLE -> IDLE on a push with last=1 (single-beat burst; reports done).
//    - BURST -> IDLE on a push with last=1.
//    - The accumulators are beat counter (9 bit) and worst response. Severity is the
//      numeric value of the response: OKAY 00 < EXOKAY 01 < SLVERR 10 < DECERR 11.
//    - On a last push, burst_done=1 the next cycle, and burst_beats/burst_resp/burst_id
//      load the accumulated values including the last beat. The accumulators then reset.
//    - At 256 beats with no last, the counter saturates at 256 and the FSM stays in BURST.
// STRUCTURE
//  - Package axi_rd_pkg holds the response encodings (RESP_OKAY, RESP_EXOKAY, RESP_SLVERR,
//    RESP_DECERR), the burst-FSM state encodings and the max burst length 256.
//  - Sub-module axi_rd_resp_fifo_mem: dual-pointer register array,
//    width data_width+2+4+1, depth DEPTH, write on push, async read at rd_ptr.
//  - The top level holds the pointers, flags, overflow and burst FSM.
// TESTING
//  1. Reset, then 4 single beats (data 0x11..0x44, last=1 each), dready=1 ->
//     dout 0x11..0x44 on consecutive cycles, one cycle after each push;
//     4 burst_done pulses, each with burst_beats=1.
//  2. Burst of 8 beats, resp 00,00,10,00,01,00,00,00, last on beat 8, dready=0 ->
//     count=8; one burst_done with beats=8, resp=2'b10; dvalid stays 1 with the head
//     held at beat 1.
//  3. DEPTH=16, 18 pushes, dready=0 -> almost_full at count 14, full at 16; beats 17 and
//     18 dropped; overflow=1; ovf_clr clears overflow.
//  4. Full FIFO with push+pop every cycle for 10 cycles -> full stays 1, no overflow, data
//     order preserved.
//  5. Pointer wrap: 40 pushes interleaved with pops at half rate, then drain -> all data in
//     order; dvalid=0 and count=0 at the end.
//  6. Assert ARst=0 after beat 3 of a 5-beat burst, release, then a 2-beat burst ->
//     outputs 0 during reset; no done pulse for the aborted burst; new burst_beats=2.

Source files
------------

// File: rtl/axi_master_read_resp_buffer_pkg.sv
// axi_rd_pkg: response encodings, burst FSM states and burst limit for the read response buffer
package axi_rd_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int MAX_BURST = 256;
  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} burst_state_e;
  function automatic logic [1:0] worse_resp(input logic [1:0] a, input logic [1:0] b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/axi_master_read_resp_buffer_if.sv
// axi_master_read_resp_buffer_if: head-of-FIFO valid/ready channel towards the decoder
interface axi_master_read_resp_buffer_if #(parameter int data_width = 64);
  logic [data_width-1:0] dout;
  logic [1:0] dresp;
  logic [3:0] did;
  logic dlast;
  logic dvalid;
  logic dready;
  modport master(output dout, dresp, did, dlast, dvalid, input dready);
  modport slave(input dout, dresp, did, dlast, dvalid, output dready);
endinterface

// File: rtl/axi_master_read_resp_buffer_fifo_mem.sv
// axi_rd_resp_fifo_mem: register array with synchronous write and asynchronous read
module axi_rd_resp_fifo_mem #(
  parameter int W = 71,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic AClk,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [DEPTH];
  // store one beat per accepted push
  always_ff @(posedge AClk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/axi_master_read_resp_buffer.sv
// axi_master_read_resp_buffer: FWFT beat buffer with burst summary and overflow tracking
module axi_master_read_resp_buffer
  import axi_rd_pkg::*;
#(
  parameter int data_width = 64,
  parameter int DEPTH = 16,
  parameter int AF_MARGIN = 2
) (
  input  logic AClk,
  input  logic ARst,
  input  logic [data_width-1:0] rdata_d,
  input  logic [1:0] rresp_d,
  input  logic [3:0] rid_d,
  input  logic r_last_d,
  input  logic rd_rsp_en_d,
  axi_master_read_resp_buffer_if.master dq,
  output logic burst_done,
  output logic [8:0] burst_beats,
  output logic [1:0] burst_resp,
  output logic [3:0] burst_id,
  output logic almost_full,
  output logic full,
  output logic overflow,
  input  logic ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int W = data_width + 7;
  logic [AW:0] wr_ptr, rd_ptr, count, count_nxt;
  logic [W-1:0] head;
  logic push, pop, drop;
  burst_state_e state, state_nxt;
  logic [8:0] beats, beats_inc;
  logic [1:0] worst, worst_nxt;
  assign dq.dvalid = wr_ptr != rd_ptr;
  assign pop = dq.dvalid & dq.dready;
  assign push = rd_rsp_en_d & (~full | pop);
  assign drop = rd_rsp_en_d & full & ~pop;
  assign count = wr_ptr - rd_ptr;
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
  assign {dq.dout, dq.dresp, dq.did, dq.dlast} = dq.dvalid ? head : '0;
  axi_rd_resp_fifo_mem #(.W(W), .DEPTH(DEPTH)) u_mem (
    .AClk(AClk),
    .we(push),
    .waddr(wr_ptr[AW-1:0]),
    .wdata({rdata_d, rresp_d, rid_d, r_last_d}),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(head)
  );
  // pointers, registered fill flags and sticky overflow
  always_ff @(posedge AClk or negedge ARst)
    if (!ARst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full <= 1'b0;
      almost_full <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
      full <= count_nxt == (AW+1)'(DEPTH);
      almost_full <= count_nxt >= (AW+1)'(DEPTH - AF_MARGIN);
      overflow <= drop | (overflow & ~ovf_clr);
    end
  // a fresh burst starts counting from this beat; dropped beats still count
  assign beats_inc = state == S_IDLE ? 9'd1 : beats == 9'(MAX_BURST) ? beats : beats + 9'd1;
  assign worst_nxt = state == S_IDLE ? rresp_d : worse_resp(worst, rresp_d);
  // burst FSM next state
  always_comb begin
    state_nxt = state;
    if (rd_rsp_en_d) state_nxt = r_last_d ? S_IDLE : S_BURST;
  end
  // burst FSM state register
  always_ff @(posedge AClk or negedge ARst)
    if (!ARst) state <= S_IDLE;
    else state <= state_nxt;
  // burst accumulators and the per-burst summary
  always_ff @(posedge AClk or negedge ARst)
    if (!ARst) begin
      beats <= '0;
      worst <= RESP_OKAY;
      burst_done <= 1'b0;
      burst_beats <= '0;
      burst_resp <= RESP_OKAY;
      burst_id <= '0;
    end else begin
      burst_done <= rd_rsp_en_d & r_last_d;
      if (rd_rsp_en_d & r_last_d) begin
        burst_beats <= beats_inc;
        burst_resp <= worst_nxt;
        burst_id <= rid_d;
        beats <= '0;
        worst <= RESP_OKAY;
      end else if (rd_rsp_en_d) begin
        beats <= beats_inc;
        worst <= worst_nxt;
      end
    end
endmodule

// File: tb/tb_axi_master_read_resp_buffer.sv
// tb_axi_master_read_resp_buffer: vector table plus model-checked sequences for the read response buffer
module tb_axi_master_read_resp_buffer;
  logic AClk = 1'b0;
  logic ARst = 1'b0;
  logic [63:0] rdata_d = '0;
  logic [1:0] rresp_d = '0;
  logic [3:0] rid_d = '0;
  logic r_last_d = 1'b0;
  logic rd_rsp_en_d = 1'b0;
  logic ovf_clr = 1'b0;
  logic burst_done, almost_full, full, overflow;
  logic [8:0] burst_beats;
  logic [1:0] burst_resp;
  logic [3:0] burst_id;
  int checks = 0;
  int failures = 0;
  logic [63:0] q[$];
  int m_acc = 0;
  logic [1:0] m_worst = '0;
  logic m_ovf = 1'b0, m_done = 1'b0;
  logic [8:0] m_bb = '0;
  logic [1:0] m_br = '0;
  logic [3:0] m_bid = '0;
  axi_master_read_resp_buffer_if #(.data_width(64)) dq ();
  axi_master_read_resp_buffer #(.data_width(64), .DEPTH(16), .AF_MARGIN(2)) dut (
    .AClk(AClk),
    .ARst(ARst),
    .rdata_d(rdata_d),
    .rresp_d(rresp_d),
    .rid_d(rid_d),
    .r_last_d(r_last_d),
    .rd_rsp_en_d(rd_rsp_en_d),
    .dq(dq.master),
    .burst_done(burst_done),
    .burst_beats(burst_beats),
    .burst_resp(burst_resp),
    .burst_id(burst_id),
    .almost_full(almost_full),
    .full(full),
    .overflow(overflow),
    .ovf_clr(ovf_clr)
  );
  always #5 AClk = ~AClk;
  typedef struct {
    logic en, last;
    logic [1:0] resp;
    logic [3:0] id;
    logic [63:0] data;
    logic rdy;
    logic e_valid;
    logic [63:0] e_dout;
    logic e_done;
    logic [8:0] e_beats;
    logic [1:0] e_resp;
    logic [3:0] e_bid;
    int e_count;
  } vec_t;
  vec_t tbl[15];
  logic [1:0] r2[8] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
  function automatic vec_t mk(logic en, logic last, logic [1:0] resp, logic [3:0] id, logic [63:0] data,
                              logic rdy, logic ev, logic [63:0] ed, logic edone, logic [8:0] eb,
                              logic [1:0] er, logic [3:0] ei, int ec);
    vec_t v;
    v.en = en; v.last = last; v.resp = resp; v.id = id; v.data = data; v.rdy = rdy;
    v.e_valid = ev; v.e_dout = ed; v.e_done = edone; v.e_beats = eb; v.e_resp = er; v.e_bid = ei; v.e_count = ec;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic do_reset();
    rd_rsp_en_d = 1'b0; r_last_d = 1'b0; ovf_clr = 1'b0; dq.dready = 1'b0;
    ARst = 1'b0;
    #1;
    chk("reset_outs", {dq.dout, dq.dresp, dq.did, dq.dlast, dq.dvalid, burst_done, burst_beats, burst_resp,
                       burst_id, almost_full, full, overflow}, '0);
    @(posedge AClk); #1;
    ARst = 1'b1;
    q.delete();
    m_acc = 0; m_worst = '0; m_ovf = 1'b0; m_done = 1'b0; m_bb = '0; m_br = '0; m_bid = '0;
  endtask
  task automatic step(input logic en, input logic last, input logic [1:0] resp, input logic [3:0] id,
                      input logic [63:0] data, input logic rdy, input logic clr);
    logic pop, acc;
    rd_rsp_en_d = en; r_last_d = last; rresp_d = resp; rid_d = id; rdata_d = data; dq.dready = rdy; ovf_clr = clr;
    pop = rdy && q.size() != 0;
    acc = en && (q.size() < 16 || pop);
    if (pop) chk("head_order", dq.dout, q[0]);
    @(posedge AClk); #1;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(data);
    if (en && !acc) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_done = 1'b0;
    if (en) begin
      m_acc = m_acc >= 256 ? 256 : m_acc + 1;
      m_worst = resp > m_worst ? resp : m_worst;
      if (last) begin
        m_done = 1'b1; m_bb = 9'(m_acc); m_br = m_worst; m_bid = id; m_acc = 0; m_worst = '0;
      end
    end
    chk("dvalid", dq.dvalid, q.size() != 0);
    chk("count", dut.count, q.size());
    chk("full", full, q.size() == 16);
    chk("almost_full", almost_full, q.size() >= 14);
    chk("overflow", overflow, m_ovf);
    chk("burst_done", burst_done, m_done);
    chk("burst_summary", {burst_beats, burst_resp, burst_id}, {m_bb, m_br, m_bid});
    rd_rsp_en_d = 1'b0; ovf_clr = 1'b0;
  endtask
  task automatic drain();
    for (int n = 0; n < 40 && q.size() != 0; n++) step(1'b0, 1'b0, 2'd0, 4'd0, 64'd0, 1'b1, 1'b0);
    chk("drained", {dq.dvalid, dut.count}, '0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    tbl[0] = mk(1, 1, 2'd0, 4'd0, 64'h11, 1, 1, 64'h11, 1, 9'd1, 2'd0, 4'd0, 1);
    tbl[1] = mk(1, 1, 2'd1, 4'd1, 64'h22, 1, 1, 64'h22, 1, 9'd1, 2'd1, 4'd1, 1);
    tbl[2] = mk(1, 1, 2'd3, 4'd2, 64'h33, 1, 1, 64'h33, 1, 9'd1, 2'd3, 4'd2, 1);
    tbl[3] = mk(1, 1, 2'd2, 4'd3, 64'h44, 1, 1, 64'h44, 1, 9'd1, 2'd2, 4'd3, 1);
    tbl[4] = mk(0, 0, 2'd0, 4'd0, 64'h00, 1, 0, 64'h00, 0, 9'd1, 2'd2, 4'd3, 0);
    for (int i = 0; i < 8; i++)
      tbl[5+i] = mk(1, i == 7, r2[i], 4'd5, 64'hA0 + 64'(i), 0, 1, 64'hA0, i == 7,
                    i == 7 ? 9'd8 : 9'd1, 2'd2, i == 7 ? 4'd5 : 4'd3, i + 1);
    tbl[13] = mk(0, 0, 2'd0, 4'd0, 64'h00, 0, 1, 64'hA0, 0, 9'd8, 2'd2, 4'd5, 8);
    tbl[14] = mk(0, 0, 2'd0, 4'd0, 64'h00, 0, 1, 64'hA0, 0, 9'd8, 2'd2, 4'd5, 8);
    do_reset();
    for (int i = 0; i < 15; i++) begin
      rd_rsp_en_d = tbl[i].en; r_last_d = tbl[i].last; rresp_d = tbl[i].resp; rid_d = tbl[i].id;
      rdata_d = tbl[i].data; dq.dready = tbl[i].rdy;
      @(posedge AClk); #1;
      chk($sformatf("vec%0d_dvalid", i), dq.dvalid, tbl[i].e_valid);
      chk($sformatf("vec%0d_dout", i), dq.dout, tbl[i].e_dout);
      chk($sformatf("vec%0d_done", i), burst_done, tbl[i].e_done);
      chk($sformatf("vec%0d_summary", i), {burst_beats, burst_resp, burst_id}, {tbl[i].e_beats, tbl[i].e_resp, tbl[i].e_bid});
      chk($sformatf("vec%0d_count", i), dut.count, tbl[i].e_count);
    end
    rd_rsp_en_d = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dq.dready = 1'b1;
      chk("burst8_drain", dq.dout, 64'hA0 + 64'(i));
      @(posedge AClk); #1;
    end
    chk("burst8_empty", dq.dvalid, 1'b0);
    do_reset();
    for (int k = 1; k <= 18; k++) step(1'b1, 1'b0, k == 17 ? 2'd3 : 2'd0, 4'd7, 64'(k), 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 4'd0, 64'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 2'd0, 4'd7, 64'hDEAD, 1'b0, 1'b1);
    step(1'b0, 1'b0, 2'd0, 4'd0, 64'd0, 1'b0, 1'b1);
    for (int j = 0; j < 10; j++) step(1'b1, 1'b0, 2'd0, 4'd7, 64'h200 + 64'(j), 1'b1, 1'b0);
    drain();
    for (int j = 0; j < 80; j++) step(j % 2 == 0, 1'b0, 2'd1, 4'd7, 64'h300 + 64'(j), j % 2 == 1, 1'b0);
    drain();
    step(1'b1, 1'b1, 2'd0, 4'd9, 64'h400, 1'b1, 1'b0);
    drain();
    for (int j = 0; j < 3; j++) step(1'b1, 1'b0, 2'd3, 4'd2, 64'h500 + 64'(j), 1'b0, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 2'd0, 4'd6, 64'h600, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'd1, 4'd6, 64'h601, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 4'd0, 64'd0, 1'b0, 1'b0);
    drain();
    for (int j = 0; j < 300; j++) step(1'b1, 1'b0, 2'd0, 4'd1, 64'(j), 1'b1, 1'b0);
    step(1'b1, 1'b1, 2'd2, 4'd4, 64'h7FF, 1'b1, 1'b0);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
